// File: rtl/capture_sequencer_if.sv
// Handshake between the capture sequencer (master) and the BRAM capture engine (slave):
// level enable, decimation code, and the engine's completion flag.
interface capture_sequencer_if #(
    parameter int DEC_W = 22
);
    logic             cap_enable_o;
    logic [DEC_W-1:0] cap_dec_code_o;
    logic             cap_done_i;

    modport master (
        output cap_enable_o,
        output cap_dec_code_o,
        input  cap_done_i
    );

    modport slave (
        input  cap_enable_o,
        input  cap_dec_code_o,
        output cap_done_i
    );
endinterface

// File: rtl/capture_sequencer.sv
// Round-robin sequencer sharing one BRAM capture engine between N_REQ requesters, with timeout/abort.
// Optional statistics counters are compiled in when CAP_SEQ_STATS_EN is defined.
module capture_sequencer #(
    parameter int N_REQ = 3,
    parameter int DEC_W = 22,
    parameter int TO_W  = 32,
    parameter int GAP   = 2
) (
    input  logic                   pdh_clk,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*DEC_W-1:0] dec_code_i,
    input  logic [TO_W-1:0]        timeout_cycles_i,
    input  logic                   abort_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [N_REQ-1:0]       timeout_o,
`ifdef CAP_SEQ_STATS_EN
    input  logic                   stats_clr_i,
    output logic [31:0]            cap_count_o,
    output logic [31:0]            to_count_o,
`endif
    capture_sequencer_if.master    cap
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_DONE,
        RELEASE
    } state_t;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [PW-1:0]    PTR_LAST = PW'(N_REQ - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [TO_W-1:0]     to_cnt;
    logic                to_en;
    logic [GW-1:0]       gap_cnt;

    logic [2*N_REQ-1:0]  req_rot;
    logic                rr_hit;
    logic [PW-1:0]       rr_win;
    logic [DEC_W-1:0]    win_code;
    logic                to_expire;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        int w;
        req_rot  = {req_i, req_i} >> rr_ptr;
        rr_hit   = 1'b0;
        rr_win   = '0;
        win_code = '0;
        w        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!rr_hit && req_rot[i]) begin
                rr_hit = 1'b1;
                w      = int'(rr_ptr) + i;
                if (w >= N_REQ) w = w - N_REQ;
                rr_win = PW'(w);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_win == PW'(i)) win_code = dec_code_i[i*DEC_W +: DEC_W];
        end
    end

    // Expire on the cycle the counter would reach zero; a zero load disables the timeout.
    assign to_expire = to_en && (to_cnt <= TO_W'(1));
    assign busy_o    = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pdh_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            to_cnt             <= '0;
            to_en              <= 1'b0;
            gap_cnt            <= '0;
            grant_o            <= '0;
            done_o             <= '0;
            timeout_o          <= '0;
            cap.cap_enable_o   <= 1'b0;
            cap.cap_dec_code_o <= '0;
        end else begin
            done_o    <= '0;
            timeout_o <= '0;
            case (state)
                IDLE: begin
                    if (rr_hit) begin
                        grant_o            <= ONE_HOT0 << rr_win;
                        cap.cap_dec_code_o <= (win_code == '0) ? DEC_W'(1) : win_code;
                        rr_ptr             <= (rr_win == PTR_LAST) ? '0 : rr_win + 1'b1;
                        state              <= START;
                    end
                end
                START: begin
                    to_cnt <= timeout_cycles_i;
                    to_en  <= |timeout_cycles_i;
                    if (abort_i) begin
                        timeout_o <= grant_o;
                        gap_cnt   <= '0;
                        state     <= RELEASE;
                    end else begin
                        cap.cap_enable_o <= 1'b1;
                        state            <= WAIT_LOW;
                    end
                end
                WAIT_LOW, WAIT_DONE: begin
                    // A completion seen in WAIT_DONE beats a simultaneous abort or expiry.
                    if (state == WAIT_DONE && cap.cap_done_i) begin
                        done_o           <= grant_o;
                        cap.cap_enable_o <= 1'b0;
                        to_cnt           <= '0;
                        gap_cnt          <= '0;
                        state            <= RELEASE;
                    end else if (abort_i || to_expire) begin
                        timeout_o        <= grant_o;
                        cap.cap_enable_o <= 1'b0;
                        to_cnt           <= '0;
                        gap_cnt          <= '0;
                        state            <= RELEASE;
                    end else begin
                        if (to_en && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
                        if (state == WAIT_LOW && !cap.cap_done_i) state <= WAIT_DONE;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        grant_o <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAP_SEQ_STATS_EN
    always_ff @(posedge pdh_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_count_o <= '0;
            to_count_o  <= '0;
        end else if (stats_clr_i) begin
            cap_count_o <= '0;
            to_count_o  <= '0;
        end else begin
            if (|done_o)    cap_count_o <= cap_count_o + 32'd1;
            if (|timeout_o) to_count_o  <= to_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences the BRAM capture/DMA path. Shares the single capture engine between N_REQ requesters (e.g. CPU command, error-threshold trigger, periodic timer).
- Issues the level enable and the decimation code to the capture engine, then tracks its completion flag.
- Guards each capture with a timeout and returns a per-requester done or timeout pulse.
- Sits in the pdh_clk domain, between the request sources and the BRAM capture controller.

Parameters:
- N_REQ, 3, number of requesters (1..8).
- DEC_W, 22, decimation code width; matches the capture engine.
- TO_W, 32, timeout counter width.
- GAP, 2, minimum pdh_clk cycles cap_enable_o is held low between captures (≥2, so the engine's edge detector re-arms).

Ports:
- pdh_clk  in  1  system clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  level request per requester; held until its done_o or timeout_o pulse.
- dec_code_i  in  N_REQ*DEC_W  per-requester decimation code; slice k is requester k.
- timeout_cycles_i  in  TO_W  capture timeout in cycles; 0 disables the timeout.
- abort_i  in  1  synchronous abort of the current capture.
- grant_o  out  N_REQ  one-hot grant; held for the whole capture.
- busy_o  out  1  high in any state other than IDLE.
- cap_enable_o  out  1  level enable to the capture engine.
- cap_dec_code_o  out  DEC_W  decimation code to the capture engine; stable while cap_enable_o=1.
- cap_done_i  in  1  capture engine transaction_complete; stays high until the next enable edge.
- done_o  out  N_REQ  1-cycle completion pulse to the granted requester.
- timeout_o  out  N_REQ  1-cycle timeout/abort pulse to the granted requester.

Behaviour:
- Reset (rst_ni=0, async):
  - state=IDLE, round-robin pointer=0, timeout counter=0.
  - All outputs 0, including cap_dec_code_o.
  - Reset mid-capture drops cap_enable_o and grant_o immediately; no done_o or timeout_o pulse is issued.
- States: IDLE, START, WAIT_LOW, WAIT_DONE, RELEASE.
- IDLE:
  - If any req_i is set, round-robin arbitration picks the first set bit at or above the pointer, wrapping at N_REQ.
  - Registered: grant_o, cap_dec_code_o = slice of the winner (code 0 is coerced to 1), pointer = winner+1 mod N_REQ.
  - Next state START. Grant is visible 1 cycle after req_i is sampled.
- START:
  - cap_enable_o=1; timeout counter loaded with timeout_cycles_i.
  - Next state WAIT_LOW.
- WAIT_LOW:
  - Waits for cap_done_i=0, which confirms the engine has left its done state.
  - If cap_done_i is already 0, exits after 1 cycle.
  - Next state WAIT_DONE.
- WAIT_DONE:
  - On cap_done_i=1: pulse done_o[winner] for 1 cycle, then go to RELEASE.
- Enable and grant:
  - cap_enable_o stays 1 from START through WAIT_DONE.
  - cap_enable_o is 0 in RELEASE and IDLE.
  - grant_o is held from IDLE exit until RELEASE exit.
- Timeout:
  - The counter decrements in WAIT_LOW and WAIT_DONE when timeout_cycles_i≠0 at START.
  - When it reaches 0: pulse timeout_o[winner], no done_o, go to RELEASE.
- Abort:
  - abort_i in START, WAIT_LOW or WAIT_DONE: same response as a timeout.
  - abort_i in IDLE or RELEASE is ignored.
- Simultaneous events:
  - cap_done_i=1 and timeout expiry in the same cycle: done wins.
  - abort_i and cap_done_i=1 in the same cycle: done wins.
- RELEASE:
  - Holds cap_enable_o=0 for GAP cycles; grant_o=0 on exit.
  - Returns to IDLE, where arbitration resumes on the next cycle.
- Requests:
  - A req_i that drops before grant is simply not served.
  - A req_i still high after its done_o pulse is treated as a new request and rearbitrated fairly.
- Width rules:
  - cap_dec_code_o is exactly DEC_W bits, no truncation.
  - The timeout counter saturates at 0.

Optional Feature:
- CAP_SEQ_STATS_EN defined:
  - Adds outputs cap_count_o[31:0] and to_count_o[31:0], both 0 at reset.
  - cap_count_o increments on every done_o pulse; to_count_o increments on every timeout_o pulse.
  - Both wrap at 2^32.
  - Both clear synchronously when input stats_clr_i=1 (clear has priority over increment).
- Undefined: these ports and their counters are absent.

Test Plan:
- Reset:
  - Stimulus: rst_ni low with req_i=3'b111.
  - Required: all outputs 0.
  - Release reset with req_i=3'b001 and code 0: grant_o=001 after 1 cycle; cap_dec_code_o=1 (coerced); cap_enable_o=1 on the next cycle.
- Single capture:
  - Stimulus: req_i=010 with code 10; model the engine so cap_done_i rises 500 cycles after the enable edge.
  - Required: exactly one done_o=010 pulse; cap_enable_o falls and stays low ≥2 cycles; busy_o=0 afterwards.
- Round robin:
  - Stimulus: req_i=111 held continuously.
  - Required: grant order 001, 010, 100, 001; no cap_enable_o low gap shorter than GAP.
- Engine starts in done state:
  - Stimulus: cap_done_i=1 held at request time; it drops 3 cycles after the enable edge and rises 100 cycles later.
  - Required: no premature done_o; a single done_o pulse after the rise.
- Timeout:
  - Stimulus: timeout_cycles_i=50 and cap_done_i stuck at 0.
  - Required: timeout_o pulse at 50±1 cycles after START, no done_o.
  - With timeout_cycles_i=0 the sequencer waits indefinitely.
- Abort and collision:
  - Stimulus: abort_i in WAIT_DONE.
  - Required: timeout_o pulse.
  - Stimulus: abort_i and cap_done_i=1 in the same cycle.
  - Required: done_o only.
  - With CAP_SEQ_STATS_EN defined: cap_count_o and to_count_o match the pulse counts; stats_clr_i returns both to 0.
